bram_march_ctrl: RTL

Self-test sequencer for the single-port block RAM under test on the Arty-7 measurement skeleton. On a start pulse it takes exclusive control of the RAM port and runs a two-pass write/read-back march over all positions. Pass 0 uses a seeded pattern; pass 1 uses its bit-inverse. Every read-back word is compared, and the controller reports pass/fail, an error count and the first failing address to the skeleton's readout bus.

---
 rtl/bram_march_ctrl_pkg.sv | 31 +++
 rtl/bram_march_ctrl_if.sv | 21 ++
 rtl/bram_march_checker.sv | 87 ++++++++
 rtl/bram_march_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/bram_march_ctrl_pkg.sv
// Shared types and the march pattern generator for the BRAM self-test.
package bram_march_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_READ   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // Pattern arithmetic is done at a fixed width; RAM words up to PAT_W bits.
  localparam int PAT_W = 32;
  typedef logic [PAT_W-1:0] pat_t;

  // Word written/expected at address adr: (seed + adr) in pass 0, its
  // bit-inverse in pass 1, truncated to the low 'width' bits.
  function automatic pat_t expected(input pat_t seed, input pat_t adr,
                                    input logic inv, input int unsigned width);
    logic [2*PAT_W-1:0] word;
    logic [2*PAT_W-1:0] mask;
    logic [2*PAT_W-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    word   = {{PAT_W{1'b0}}, seed} + {{PAT_W{1'b0}}, adr};
    if (inv) word = ~word;
    mask = (one << width) - one;
    return pat_t'(word & mask);
  endfunction

endpackage

// File: rtl/bram_march_ctrl_if.sv
// Single-port BRAM bus: the sequencer is master, the RAM is slave.
interface bram_march_ctrl_if #(
  parameter int BITWIDTH_IN  = 12,
  parameter int BITWIDTH_ADR = 6
);
  logic                    RAM_EN;
  logic                    RAM_WE;
  logic [BITWIDTH_ADR-1:0] RAM_ADR;
  logic [BITWIDTH_IN-1:0]  RAM_DIN;
  logic [BITWIDTH_IN-1:0]  RAM_DOUT;

  modport master (
    output RAM_EN, RAM_WE, RAM_ADR, RAM_DIN,
    input  RAM_DOUT
  );

  modport slave (
    input  RAM_EN, RAM_WE, RAM_ADR, RAM_DIN,
    output RAM_DOUT
  );
endinterface

// File: rtl/bram_march_checker.sv
// Compare stage of the march test. A read issued in cycle k has its address
// and expected word registered here; the RAM data arriving in cycle k+1 is
// checked against them. Keeps the saturating error count and first failing
// address for the current test.
module bram_march_checker
  import bram_march_ctrl_pkg::*;
#(
  parameter int BITWIDTH_IN  = 12,
  parameter int BITWIDTH_ADR = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    rd_issue,
  input  logic [BITWIDTH_ADR-1:0] rd_adr,
  input  logic [BITWIDTH_IN-1:0]  rd_exp,
  input  logic [BITWIDTH_IN-1:0]  rd_data,
  output logic [BITWIDTH_ADR:0]   err_cnt,
  output logic [BITWIDTH_ADR-1:0] first_err_adr,
  output logic                    err_zero_next
);

  localparam logic [BITWIDTH_ADR:0] ERR_MAX = '1;

  logic                    cmp_v_q, cmp_v_d;
  logic [BITWIDTH_ADR-1:0] cmp_adr_q, cmp_adr_d;
  logic [BITWIDTH_IN-1:0]  cmp_exp_q, cmp_exp_d;
  logic [BITWIDTH_ADR:0]   err_cnt_q, err_cnt_d;
  logic                    first_seen_q, first_seen_d;
  logic [BITWIDTH_ADR-1:0] first_adr_q, first_adr_d;

  // Next-state for the compare pipeline, counter and first-error capture.
  always_comb begin
    cmp_v_d      = rd_issue;
    cmp_adr_d    = cmp_adr_q;
    cmp_exp_d    = cmp_exp_q;
    err_cnt_d    = err_cnt_q;
    first_seen_d = first_seen_q;
    first_adr_d  = first_adr_q;

    if (rd_issue) begin
      cmp_adr_d = rd_adr;
      cmp_exp_d = rd_exp;
    end

    if (cmp_v_q && (rd_data != cmp_exp_q)) begin
      if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + (BITWIDTH_ADR+1)'(1);
      if (!first_seen_q) begin
        first_seen_d = 1'b1;
        first_adr_d  = cmp_adr_q;
      end
    end

    if (clr) begin
      cmp_v_d      = 1'b0;
      err_cnt_d    = '0;
      first_seen_d = 1'b0;
      first_adr_d  = '0;
    end
  end

  // Compare-stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_v_q      <= 1'b0;
      cmp_adr_q    <= '0;
      cmp_exp_q    <= '0;
      err_cnt_q    <= '0;
      first_seen_q <= 1'b0;
      first_adr_q  <= '0;
    end else begin
      cmp_v_q      <= cmp_v_d;
      cmp_adr_q    <= cmp_adr_d;
      cmp_exp_q    <= cmp_exp_d;
      err_cnt_q    <= err_cnt_d;
      first_seen_q <= first_seen_d;
      first_adr_q  <= first_adr_d;
    end
  end

  // The FSM latches PASS on the same edge as the last compare lands, so it
  // needs the post-update count rather than the registered one.
  assign err_zero_next = (err_cnt_d == '0);
  assign err_cnt       = err_cnt_q;
  assign first_err_adr = first_adr_q;

endmodule

// File: rtl/bram_march_ctrl.sv
// Two-pass write/read-back march sequencer for a single-port BRAM.
// Pass 0 writes and verifies seed+adr, pass 1 its inverse.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | waiting for START, results held
// ST_WRITE  | writing expected(adr) to every position
// ST_READ   | issuing reads; data checked one cycle later
// ST_DRAIN  | RAM idle while the last read is compared; pick next pass
// ST_FINISH | DONE pulse, PASS valid
module bram_march_ctrl
  import bram_march_ctrl_pkg::*;
#(
  parameter int BITWIDTH_IN   = 12,
  parameter int BITWIDTH_ADR  = 6,
  parameter int NUM_POSITIONS = 2**BITWIDTH_ADR - 4
) (
  input  logic                    CLK_SYS,
  input  logic                    RST,
  input  logic                    START,
  input  logic                    ABORT,
  input  logic [BITWIDTH_IN-1:0]  SEED,
  bram_march_ctrl_if.master       ram,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    PASS,
  output logic [BITWIDTH_ADR:0]   ERR_CNT,
  output logic [BITWIDTH_ADR-1:0] FIRST_ERR_ADR
);

  if (NUM_POSITIONS < 2 || NUM_POSITIONS > 2**BITWIDTH_ADR) begin : g_bad_positions
    $error("bram_march_ctrl: NUM_POSITIONS out of range");
  end
  if (BITWIDTH_IN > PAT_W) begin : g_bad_width
    $error("bram_march_ctrl: BITWIDTH_IN wider than pattern generator");
  end

  localparam logic [BITWIDTH_ADR-1:0] LAST_ADR = BITWIDTH_ADR'(NUM_POSITIONS - 1);

  state_e                  state_q, state_d;
  logic                    inv_q, inv_d;
  logic [BITWIDTH_ADR-1:0] adr_q, adr_d;
  logic [BITWIDTH_IN-1:0]  seed_q, seed_d;
  logic                    pass_q, pass_d;

  logic                    start_acc;
  logic                    rd_issue;
  logic                    err_zero_next;
  logic                    at_last;
  logic [BITWIDTH_IN-1:0]  exp_word;

  assign exp_word = BITWIDTH_IN'(expected(pat_t'(seed_q), pat_t'(adr_q), inv_q, BITWIDTH_IN));
  assign at_last  = (adr_q == LAST_ADR);

  // Next-state, address walk and pass selection; ABORT overrides everything.
  always_comb begin
    state_d   = state_q;
    inv_d     = inv_q;
    adr_d     = adr_q;
    seed_d    = seed_q;
    pass_d    = pass_q;
    start_acc = 1'b0;
    rd_issue  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          start_acc = 1'b1;
          seed_d    = SEED;
          pass_d    = 1'b0;
          inv_d     = 1'b0;
          adr_d     = '0;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (at_last) begin
          adr_d   = '0;
          state_d = ST_READ;
        end else begin
          adr_d = adr_q + BITWIDTH_ADR'(1);
        end
      end
      ST_READ: begin
        rd_issue = 1'b1;
        if (at_last) state_d = ST_DRAIN;
        else         adr_d   = adr_q + BITWIDTH_ADR'(1);
      end
      ST_DRAIN: begin
        adr_d = '0;
        if (!inv_q) begin
          inv_d   = 1'b1;
          state_d = ST_WRITE;
        end else begin
          pass_d  = err_zero_next;
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        inv_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (ABORT && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      inv_d    = 1'b0;
      adr_d    = '0;
      pass_d   = 1'b0;
      rd_issue = 1'b0;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge CLK_SYS or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      inv_q   <= 1'b0;
      adr_q   <= '0;
      seed_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inv_q   <= inv_d;
      adr_q   <= adr_d;
      seed_q  <= seed_d;
      pass_q  <= pass_d;
    end
  end

  bram_march_checker #(
    .BITWIDTH_IN  (BITWIDTH_IN),
    .BITWIDTH_ADR (BITWIDTH_ADR)
  ) u_checker (
    .clk           (CLK_SYS),
    .rst           (RST),
    .clr           (start_acc),
    .rd_issue      (rd_issue),
    .rd_adr        (adr_q),
    .rd_exp        (exp_word),
    .rd_data       (ram.RAM_DOUT),
    .err_cnt       (ERR_CNT),
    .first_err_adr (FIRST_ERR_ADR),
    .err_zero_next (err_zero_next)
  );

  // RAM port and status are pure decodes of registered state, so reset
  // drops RAM_EN immediately without a clock.
  assign ram.RAM_EN  = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign ram.RAM_WE  = (state_q == ST_WRITE);
  assign ram.RAM_ADR = adr_q;
  assign ram.RAM_DIN = (state_q == ST_WRITE) ? exp_word : '0;
  assign BUSY        = (state_q != ST_IDLE);
  assign DONE        = (state_q == ST_FINISH);
  assign PASS        = pass_q;

endmodule
